uart_tx_stream: RTL and testbench

Downstream stage of the sensor crossbar: accepts the ASCII byte burst the crossbar emits (one byte per clock while its transaction strobe is high), buffers it in a FIFO and serializes it onto the board UART TX pin as 8N1. It also produces the ready signal the crossbar waits on before starting a burst, so the serializer never loses bytes at line rate.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_tx_stream.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_stream.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_stream shared types and helpers.
// Serializer state encoding, ASCII terminator bytes, baud divider.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO for the UART transmitter.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               wr_data,
   input  logic                     pop,
   output logic [7:0]               rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   free_count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        push_ok;
   logic        pop_ok;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign free_count = (AW+1)'(DEPTH) - (wr_ptr - rd_ptr);

   // pointer update; both sides may move in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage write, no reset needed on the data array
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: byte stream FIFO + 8N1 serializer with ready/overflow.
// Build option UART_TX_CRLF_EN appends CR LF after every input burst.
module uart_tx_stream
   import uart_tx_pkg::*;
#(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 115200,
   parameter int FIFO_DEPTH   = 16,
   parameter int READY_MARGIN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       uart_txd,
   output logic       busy,
   output logic       overflow
);

   localparam int DIV = baud_div(CLK_FREQ, BAUD);
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);

   logic          push_req;
   logic [7:0]    push_data;
   logic          push_drop;
   logic          ins_busy_n;
   logic          pop;
   logic          full;
   logic          empty;
   logic [7:0]    rd_data;
   logic [AW:0]   free_count;
   logic [AW:0]   free_next;

   tx_state_t     state, state_n;
   logic [CW-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic          baud_last;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_req),
      .wr_data    (push_data),
      .pop        (pop),
      .rd_data    (rd_data),
      .full       (full),
      .empty      (empty),
      .free_count (free_count)
   );

`ifdef UART_TX_CRLF_EN
   logic       prev_valid;
   logic [1:0] ins_cnt, ins_cnt_n;
   logic       burst_end;

   // push source select: crossbar byte or CR/LF terminator
   always_comb begin
      burst_end  = !tx_valid && prev_valid;
      push_req   = tx_valid;
      push_data  = tx_data;
      push_drop  = 1'b0;
      ins_cnt_n  = ins_cnt;
      unique case (1'b1)
         burst_end: ins_cnt_n = 2'd2;
         (ins_cnt == 2'd2): begin
            push_req  = 1'b1;
            push_data = ASCII_CR;
            push_drop = tx_valid;
            ins_cnt_n = 2'd1;
         end
         (ins_cnt == 2'd1): begin
            push_req  = 1'b1;
            push_data = ASCII_LF;
            push_drop = tx_valid;
            ins_cnt_n = 2'd0;
         end
         default: ;
      endcase
      ins_busy_n = (ins_cnt_n != 2'd0);
   end

   // burst edge tracking and terminator sequencing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_valid <= 1'b0;
         ins_cnt    <= 2'd0;
      end else begin
         prev_valid <= tx_valid && (ins_cnt == 2'd0);
         ins_cnt    <= ins_cnt_n;
      end
   end
`else
   // bytes pass straight from the crossbar into the FIFO
   always_comb begin
      push_req   = tx_valid;
      push_data  = tx_data;
      push_drop  = 1'b0;
      ins_busy_n = 1'b0;
   end
`endif

   assign baud_last = (baud_cnt == CW'(DIV - 1));
   assign free_next = free_count
                    - (AW+1)'(push_req && !full)
                    + (AW+1)'(pop);

   // serializer next state, shift register and FIFO pop
   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_idx_n  = bit_idx;
      shreg_n    = shreg;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shreg_n    = rd_data;
               baud_cnt_n = '0;
               state_n    = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_cnt_n = '0;
               bit_idx_n  = 3'd0;
               state_n    = DATA;
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_cnt_n = '0;
               shreg_n    = {1'b0, shreg[7:1]};
               if (bit_idx == 3'd7) state_n = STOP;
               else bit_idx_n = bit_idx + 1'b1;
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_cnt_n = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_n = rd_data;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // serializer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shreg    <= 8'h00;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         shreg    <= shreg_n;
      end
   end

   // registered line driver and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uart_txd <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         unique case (state)
            START:   uart_txd <= 1'b0;
            DATA:    uart_txd <= shreg[0];
            default: uart_txd <= 1'b1;
         endcase
         tx_ready <= (int'(free_next) >= READY_MARGIN) && !ins_busy_n;
         busy     <= (state != IDLE) || !empty;
         overflow <= overflow || (push_req && full) || push_drop;
      end
   end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: randomized bench with a UART receiver model.
// Expected line bytes come from a queue built from the pushed bursts.
module tb_uart_tx_stream;

   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int FRAME    = 10 * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       uart_txd;
   logic       busy;
   logic       overflow;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   bit         mon_en  = 1'b0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         rx_t[$];

`ifdef UART_TX_CRLF_EN
   localparam bit CRLF = 1'b1;
`else
   localparam bit CRLF = 1'b0;
`endif

   uart_tx_stream #(
      .CLK_FREQ     (CLK_FREQ),
      .BAUD         (BAUD),
      .FIFO_DEPTH   (16),
      .READY_MARGIN (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .uart_txd (uart_txd),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // independent 8N1 receiver, sampling mid-bit on falling clock edges
   always begin : rx_mon
      logic [7:0] b;
      int         s;
      @(negedge clk);
      if (mon_en && !rst && uart_txd === 1'b0) begin
         s = cyc;
         repeat (DIV / 2 - 1) @(negedge clk);
         check("rx_start", {31'd0, uart_txd}, 32'd0);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = uart_txd;
         end
         repeat (DIV) @(negedge clk);
         check("rx_stop", {31'd0, uart_txd}, 32'd1);
         rx_q.push_back(b);
         rx_t.push_back(s);
      end
   end

   // reference: a burst lands on the line as-is, plus CR LF when enabled
   task automatic model_burst(input logic [7:0] d[$]);
      foreach (d[i]) exp_q.push_back(d[i]);
      if (CRLF) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   task automatic push_bytes(input logic [7:0] d[$]);
      foreach (d[i]) begin
         tx_data  = d[i];
         tx_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      tx_valid = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      int k = 0;
      while (!tx_ready && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("ready_before_burst", {31'd0, tx_ready}, 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("idle_wait", {31'd0, busy}, 32'd0);
   endtask

   task automatic drain(input string tag, input bit contig);
      int k = 0;
      int budget;
      budget = exp_q.size() * FRAME + 300;
      while (rx_q.size() < exp_q.size() && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({tag, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
      if (contig)
         for (int i = 1; i < rx_t.size(); i++)
            check({tag, "_gap"}, rx_t[i] - rx_t[i-1], FRAME);
      exp_q.delete();
      rx_q.delete();
      rx_t.delete();
   endtask

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] d[$];
      int         k;
      int         lows;

      repeat (3) @(posedge clk);
      #1;
      check("rst_txd", {31'd0, uart_txd}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_txd", {31'd0, uart_txd}, 32'd1);
      check("post_rst_ready", {31'd0, tx_ready}, 32'd1);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_ovf", {31'd0, overflow}, 32'd0);

      // reset in the middle of a frame with bytes still queued
      d = '{8'h00, 8'h00, 8'h00};
      push_bytes(d);
      k = 0;
      while (uart_txd && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("mid_txd_fell", {31'd0, uart_txd}, 32'd0);
      repeat (25) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_txd", {31'd0, uart_txd}, 32'd1);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (!uart_txd) lows++;
      end
      check("mid_rst_line_quiet", lows, 0);
      check("mid_rst_busy_after", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // single byte 0x35: latency, frame length and busy release
      d = '{8'h35};
      model_burst(d);
      tx_data  = 8'h35;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("lat_n1_high", {31'd0, uart_txd}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("lat_n2_low", {31'd0, uart_txd}, 32'd0);
      repeat (99) @(posedge clk);
      @(negedge clk);
      check("stop_last_txd", {31'd0, uart_txd}, 32'd1);
      check("stop_last_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("busy_after_frame", {31'd0, busy}, {31'd0, CRLF});
      drain("single", 1'b0);
      wait_idle(1000);

      // six-byte ASCII burst, frames must be back to back
      wait_ready(500);
      d = '{8'h30, 8'h32, 8'h33, 8'h30, 8'h34, 8'h31};
      model_burst(d);
      push_bytes(d);
      drain("burst", 1'b1);
      wait_idle(1000);

      // two bytes: second push meets the first pop at count 1
      wait_ready(500);
      d = '{8'($urandom), 8'($urandom)};
      model_burst(d);
      push_bytes(d);
      drain("pushpop", 1'b1);
      wait_idle(1000);

`ifdef UART_TX_CRLF_EN
      // terminator insertion holds ready low until LF is written
      wait_ready(500);
      d = '{8'h30, 8'h31, 8'h32, 8'h33};
      model_burst(d);
      push_bytes(d);
      @(posedge clk);
      @(negedge clk);
      check("crlf_ready_end", {31'd0, tx_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("crlf_ready_cr", {31'd0, tx_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("crlf_ready_lf", {31'd0, tx_ready}, 32'd1);
      drain("crlf", 1'b1);
      wait_idle(1000);
`endif

      // randomized bursts with random idle gaps
      for (int b = 0; b < 6; b++) begin
         repeat ($urandom_range(3, 40)) @(posedge clk);
         #1;
         wait_ready(1500);
         d.delete();
         for (int i = 0; i < $urandom_range(1, 6); i++)
            d.push_back(8'($urandom));
         model_burst(d);
         push_bytes(d);
      end
      drain("rand", 1'b0);
      wait_idle(1000);
      check("rand_no_ovf", {31'd0, overflow}, 32'd0);

      // 18 pushes: one goes straight to the shifter, 16 fill the FIFO,
      // the last one is dropped
      d.delete();
      for (int i = 0; i < 18; i++) d.push_back(8'($urandom));
      for (int i = 0; i < 17; i++) exp_q.push_back(d[i]);
      push_bytes(d);
      check("full_ready_low", {31'd0, tx_ready}, 32'd0);
      check("full_ovf", {31'd0, overflow}, 32'd1);
      drain("full", 1'b1);
      wait_idle(1000);

      // overflow flag is sticky across later traffic
      wait_ready(500);
      d = '{8'($urandom)};
      model_burst(d);
      push_bytes(d);
      drain("sticky", 1'b0);
      check("ovf_sticky", {31'd0, overflow}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
